// File: rtl/reader_pkg.sv
// Shared state encoding, buffer depth and the read-issue rule for the
// result_reader readback engine.
package reader_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A read may issue only if its returning word is guaranteed a free slot;
  // a word leaving the buffer this cycle frees its slot in time for that.
  function automatic logic can_issue(input logic full, input logic empty,
                                     input logic in_flight, input logic pop);
    int claimed;
    claimed = (full ? FIFO_DEPTH : (empty ? 0 : 1)) + int'(in_flight) - int'(pop);
    return (claimed < FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/result_reader_if.sv
// Bus bundle between the readback engine, the result memory and the consumer.
interface result_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;

  // Memory side: one word per mem_rd_en cycle, data valid exactly one cycle
  // later. Consumer side: a word moves on any cycle with out_valid & out_ready;
  // while out_valid is high and out_ready low, out_data/out_addr hold still.
  modport master (
    output mem_addr, mem_rd_en,
    input  mem_data_in,
    output out_data, out_addr, out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en,
    output mem_data_in,
    input  out_data, out_addr, out_valid,
    output out_ready
  );
endinterface

// File: rtl/skid_fifo.sv
// Two-entry buffer holding returned words together with their source address.
module skid_fifo
  import reader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_occ == '0);
  assign o_full    = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i] <= '0;
        r_addr[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_data[r_wr_ptr] <= i_data;
        r_addr[r_wr_ptr] <= i_addr;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_data = r_data[r_rd_ptr];
  assign o_addr = r_addr[r_rd_ptr];

endmodule

// File: rtl/result_reader.sv
// Reads a block of result words from memory and streams them, with their
// addresses, to a valid/ready consumer through a two-entry buffer.
module result_reader
  import reader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output state_t            o_dbg_state,
  result_reader_if.master   bus
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_addr;
  logic              r_done;
  logic              w_issue;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head_data;
  logic [ADDR_W-1:0] w_head_addr;

  assign w_pop = !w_empty && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = (count == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (w_issue && (r_remaining == ADDR_W'(1))) w_next = ST_DRAIN;
      ST_DRAIN: if (w_empty && !r_inflight) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != ST_IDLE);
    w_issue = 1'b0;
    if (r_state == ST_READ) begin
      w_issue = can_issue(w_full, w_empty, r_inflight, w_pop);
    end
  end

  // The in-flight flag marks that mem_data_in carries a word this cycle;
  // clearing it on reset is what discards a read returning after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_done          <= 1'b0;
    end else begin
      r_done     <= (r_state == ST_DONE);
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= r_addr;
        r_addr          <= r_addr + ADDR_W'(1);
        r_remaining     <= r_remaining - ADDR_W'(1);
      end else if ((r_state == ST_IDLE) && start) begin
        r_addr      <= base_addr;
        r_remaining <= count;
      end
    end
  end

  skid_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (bus.mem_data_in),
    .i_addr  (r_inflight_addr),
    .i_pop   (w_pop),
    .o_data  (w_head_data),
    .o_addr  (w_head_addr),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.mem_addr  = r_addr;
  assign bus.mem_rd_en = w_issue;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head_data;
  assign bus.out_addr  = w_head_addr;
  assign done          = r_done;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_result_reader.sv
// Directed-plus-random bench for result_reader: a memory responder, a word
// queue built from the readback rules, and per-cycle protocol checks.
module tb_result_reader;
  import reader_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] count;
  logic          busy;
  logic          done;
  state_t        dbg_state;

  result_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  result_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state),
    .bus         (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [15:0] salt;
  logic [15:0] exp_rd_addr;
  logic [15:0] pend_addr;
  logic        pend_v;
  logic        prev_stall;
  logic        prev_done;
  logic [31:0] prev_word;
  int rd_left, issued, accepted, rd_total, done_cnt, cyc;
  int first_rd, first_out, last_out;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'(a * 3) ^ salt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then observe.
  task automatic tick(input logic rdy, input logic st);
    logic [31:0] word;
    @(negedge clk);
    bus.out_ready   = rdy;
    start           = st;
    bus.mem_data_in = pend_v ? mem_word(pend_addr) : 16'($urandom);
    #1;
    cyc++;
    pend_v    = (bus.mem_rd_en === 1'b1);
    pend_addr = bus.mem_addr;
    word      = {bus.out_addr, bus.out_data};
    if (bus.mem_rd_en === 1'b1) begin
      check("rd_within_count", 32'(rd_left > 0), 32'd1);
      check("rd_addr", 32'(bus.mem_addr), 32'(exp_rd_addr));
      exp_rd_addr = exp_rd_addr + 16'd1;
      rd_left--;
      issued++;
      rd_total++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (prev_stall) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_word", word, prev_word);
    end
    if ((bus.out_valid === 1'b1) && rdy) begin
      if (exp_q.size() == 0) check("unexpected_word", 32'd0, 32'd1);
      else                   check("out_word", word, exp_q.pop_front());
      accepted++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    prev_stall = (bus.out_valid === 1'b1) && !rdy;
    prev_word  = word;
    check("fifo_space", 32'((issued - accepted) <= FIFO_DEPTH), 32'd1);
    if (done === 1'b1) begin
      check("done_single", 32'(prev_done), 32'd0);
      check("busy_low_at_done", 32'(busy), 32'd0);
      done_cnt++;
    end
    prev_done = (done === 1'b1);
  endtask

  task automatic check_zero(input string p);
    check({p, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({p, "_rd_en"},     32'(bus.mem_rd_en), 32'd0);
    check({p, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({p, "_out_data"},  32'(bus.out_data),  32'd0);
    check({p, "_out_addr"},  32'(bus.out_addr),  32'd0);
    check({p, "_busy"},      32'(busy),          32'd0);
    check({p, "_done"},      32'(done),          32'd0);
  endtask

  // rmode: 0 ready=1, 1 pattern 1,0,0,1, 2 random.
  // smode: 0 start low, 1 start held high, 2 random pulses while words remain.
  task automatic run(input logic [15:0] base, input logic [15:0] cnt, input int rmode,
                     input int smode, input bit launch, input int abort_at);
    int k, d0, rd0;
    bit aborted;
    logic rdy, st;
    logic [3:0] pat;
    logic [15:0] a;
    pat = 4'b1001;
    k = 0;
    aborted = 1'b0;
    exp_q.delete();
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 16'(i);
      exp_q.push_back({a, mem_word(a)});
    end
    exp_rd_addr = base;
    rd_left     = int'(cnt);
    issued      = 0;
    accepted    = 0;
    first_rd    = -1;
    first_out   = -1;
    last_out    = -1;
    d0          = done_cnt;
    rd0         = rd_total;
    base_addr   = base;
    count       = cnt;
    if (launch) begin
      tick(1'b1, 1'b1);
      check("busy_at_launch", 32'(busy), 32'd0);
    end else begin
      tick(1'b1, 1'b0);
      check("relaunch_busy", 32'(busy), 32'd1);
    end
    while ((done_cnt == d0) && (k < 400) && !aborted) begin
      if ((abort_at >= 0) && (accepted >= abort_at)) begin
        rst = 1'b1;
        tick(1'b1, 1'b0);
        rst = 1'b0;
        check_zero("abort");
        exp_q.delete();
        rd_left    = 0;
        issued     = 0;
        accepted   = 0;
        prev_stall = 1'b0;
        aborted    = 1'b1;
      end else begin
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = pat[k % 4];
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        case (smode)
          1:       st = 1'b1;
          2:       st = (accepted < int'(cnt)) ? 1'($urandom_range(0, 1)) : 1'b0;
          default: st = 1'b0;
        endcase
        tick(rdy, st);
        k++;
      end
    end
    check("timeout", 32'(k < 400), 32'd1);
    if (aborted) begin
      repeat (6) tick(1'b1, 1'b0);
      check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    end else begin
      check("done_seen", 32'(done_cnt - d0), 32'd1);
      check("all_words", 32'(exp_q.size()), 32'd0);
      check("rd_count", 32'(rd_total - rd0), 32'(cnt));
      check("busy_after_done", 32'(busy), 32'd0);
      if ((rmode == 0) && (cnt != 16'd0)) begin
        check("first_latency", 32'(first_out - first_rd), 32'd2);
        check("throughput", 32'(last_out - first_out), 32'(int'(cnt) - 1));
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    base_addr       = '0;
    count           = '0;
    bus.out_ready   = 1'b0;
    bus.mem_data_in = '0;
    salt = 16'd0; exp_rd_addr = 16'd0; pend_addr = 16'd0; pend_v = 1'b0;
    prev_stall = 1'b0; prev_done = 1'b0; prev_word = '0;
    rd_left = 0; issued = 0; accepted = 0; rd_total = 0; done_cnt = 0; cyc = 0;
    first_rd = -1; first_out = -1; last_out = -1;

    // reset, with start asserted during reset
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    check_zero("reset");
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick(1'b1, 1'b0);
    check("start_ignored_in_reset", 32'(busy), 32'd0);

    // words addr*3 from 0x0010
    salt = 16'd0;
    run(16'h0010, 16'd4, 0, 0, 1'b1, -1);

    // count = 0: busy one cycle, done two cycles after start, no reads
    base_addr = 16'h1234;
    count     = 16'd0;
    exp_q.delete();
    rd_left = 0;
    tick(1'b1, 1'b1);
    check("c0_busy_t0", 32'(busy), 32'd0);
    check("c0_done_t0", 32'(done), 32'd0);
    tick(1'b1, 1'b0);
    check("c0_busy_t1", 32'(busy), 32'd1);
    check("c0_done_t1", 32'(done), 32'd0);
    tick(1'b1, 1'b0);
    check("c0_busy_t2", 32'(busy), 32'd0);
    check("c0_done_t2", 32'(done), 32'd1);
    tick(1'b1, 1'b0);
    check("c0_done_t3", 32'(done), 32'd0);

    // address wrap
    salt = 16'($urandom);
    run(16'hFFFE, 16'd4, 0, 0, 1'b1, -1);

    // consumer stalls 1,0,0,1
    salt = 16'($urandom);
    run(16'($urandom), 16'd8, 1, 0, 1'b1, -1);

    // random backpressure and start pulses while busy
    for (int n = 0; n < 3; n++) begin
      salt = 16'($urandom);
      run(16'($urandom), 16'($urandom_range(1, 12)), 2, 2, 1'b1, -1);
    end

    // reset after five words, then a normal short readback
    salt = 16'($urandom);
    run(16'h0200, 16'd16, 0, 0, 1'b1, 5);
    run(16'h0300, 16'd2, 0, 0, 1'b1, -1);

    // start held through DONE: the second readback launches from IDLE
    salt = 16'($urandom);
    run(16'h0420, 16'd5, 0, 1, 1'b1, -1);
    run(16'h0420, 16'd5, 0, 0, 1'b0, -1);
    repeat (3) tick(1'b1, 1'b0);
    check("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 SHALL have parameter ADDR_W, 16, memory address width.
REQ-002 SHALL have parameter DATA_W, 16, memory word width.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  launch readback; driven from processor end_process.
REQ-006 SHALL have port base_addr  input  ADDR_W  first address to read, sampled on launch.
REQ-007 SHALL have port count  input  ADDR_W  number of words to read, sampled on launch.
REQ-008 SHALL have port mem_addr  output  ADDR_W  memory read address (com_addr side).
REQ-009 SHALL have port mem_rd_en  output  1  memory read strobe, one word per high cycle.
REQ-010 SHALL have port mem_data_in  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-011 SHALL have port out_data  output  DATA_W  word to consumer.
REQ-012 SHALL have port out_addr  output  ADDR_W  address the out_data word came from.
REQ-013 SHALL have port out_valid  output  1  out_data/out_addr valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
REQ-015 SHALL have port busy  output  1  high from launch until done.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last word transferred.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-018 In IDLE, start=1 SHALL latch base_addr/count, set busy next cycle, go READ (count>0) or DONE (count=0).
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 In READ, mem_rd_en SHALL assert only when buffer occupancy plus in-flight reads < 2.
REQ-021 Each issued read SHALL increment mem_addr by 1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
REQ-022 Returned word SHALL be written into a 2-entry FIFO with its address, one cycle after issue; no word SHALL ever be dropped or duplicated.
REQ-023 After count reads issued, state SHALL go DRAIN; mem_rd_en SHALL stay 0.
REQ-024 DRAIN SHALL go DONE when FIFO empty and no read in flight.
REQ-025 DONE SHALL assert done for exactly one cycle, deassert busy same cycle, return to IDLE.
REQ-026 out_valid SHALL equal FIFO not-empty; out_data/out_addr SHALL hold stable while out_valid & !out_ready.
REQ-027 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-028 With out_ready held 1, throughput SHALL be one word per cycle; first out_valid 2 cycles after first mem_rd_en... i.e. data registered into FIFO the cycle after return.
REQ-029 Words SHALL leave in ascending (wrapping) address order.

Reset
REQ-030 rst=1 SHALL, at the next posedge, force state IDLE, clear FIFO and in-flight flag, and drive mem_addr=0, mem_rd_en=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0.
REQ-031 rst mid-operation SHALL abort the transfer with no done pulse; a read returning after reset SHALL be discarded.
REQ-032 rst SHALL take priority over start in the same cycle.

Structure
REQ-033 State encoding and FIFO depth constant (2) SHALL live in shared package reader_pkg.
REQ-034 The 2-entry buffer SHALL be sub-module skid_fifo (data+address, push/pop/full/empty).

Verification
REQ-035 base=0x0010, count=4, out_ready=1, memory word=addr*3 -> out words 0x30,0x33,0x36,0x39 at addrs 0x10..0x13, one done pulse, 4 rd_en cycles.
REQ-036 count=0, start=1 -> no mem_rd_en, done pulse 2 cycles after start, busy high exactly 1 cycle.
REQ-037 base=0xFFFE, count=4 -> out_addr sequence 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-038 count=8, out_ready toggled 1,0,0,1 repeating -> all 8 words in order, none lost, out_data stable during stalls, rd_en never exceeds FIFO space.
REQ-039 count=16, rst pulsed after 5 words transferred -> all outputs 0 next cycle, no done, subsequent start with count=2 works normally.
REQ-040 start held high through and after DONE -> second readback begins only from IDLE; start pulses while busy cause no extra reads.
